// File: rtl/fib_pkg.sv
// fib_pkg: shared definitions for the Fibonacci datapath.
//   - fib_state_t : sequencer state encoding (IDLE/RUN/DONE)
//   - ALU_SEL_*   : ALU select codes (sel[3]=0 selects the arith unit)
//   - PSW_*       : bit positions inside the ALU flag word {z,n,c,v}
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_t;

    localparam logic [3:0] ALU_SEL_ADD = 4'b0000;

    localparam int PSW_Z = 3;
    localparam int PSW_N = 2;
    localparam int PSW_C = 1;
    localparam int PSW_V = 0;

    // One-hot mask selecting the carry bit of the flag word.
    localparam logic [3:0] PSW_C_MASK = 4'(1 << PSW_C);

endpackage

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: initiator-side sequencer for the shared combinational ALU.
// Computes the unsigned Fibonacci number F(n) with one ALU add per clock and
// aborts early, flagging overflow, when the ALU reports a carry.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   request to compute F(n); sampled only in IDLE
//   n        in   Fibonacci index, captured on the accepted start
//   alu_out  in   ALU result
//   alu_psw  in   ALU flags {z,n,c,v}; only carry is used
//   opa      out  ALU operand A (register a)
//   opb      out  ALU operand B (register b)
//   sel      out  ALU select, constant SEL_ADD
//   busy     out  high while iterating (RUN)
//   done     out  one-cycle completion pulse (DONE)
//   result   out  F(n), or the truncated sum on overflow; held until next finish
//   ovf      out  overflow flag for the last result
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int         bw      = 8,
    parameter logic [3:0] SEL_ADD = ALU_SEL_ADD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [bw-1:0] n,
    input  logic [bw-1:0] alu_out,
    input  logic [3:0]    alu_psw,
    output logic [bw-1:0] opa,
    output logic [bw-1:0] opb,
    output logic [3:0]    sel,
    output logic          busy,
    output logic          done,
    output logic [bw-1:0] result,
    output logic          ovf
);

    localparam logic [bw-1:0] ONE = bw'(1);

    fib_state_t    state, state_nxt;
    logic [bw-1:0] a, b, cnt;
    logic          carry;

    // Mask the whole flag word rather than pick one bit: z, n and v are
    // deliberately ignored, only carry marks overflow.
    assign carry = (alu_psw & PSW_C_MASK) != 4'b0000;

    assign opa = a;
    assign opb = b;
    assign sel = SEL_ADD;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == ONE || carry) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            cnt    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        ovf <= 1'b0;
                        if (n == '0) begin
                            result <= '0;
                        end else begin
                            a   <= '0;
                            b   <= ONE;
                            cnt <= n;
                        end
                    end
                end
                RUN: begin
                    if (cnt == ONE) begin
                        result <= b;
                    end else begin
                        a   <= b;
                        b   <= alu_out;
                        cnt <= cnt - ONE;
                        // Carry out of this add: the true F(n) no longer fits,
                        // so report the truncated sum and stop here.
                        if (carry) begin
                            result <= alu_out;
                            ovf    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
module tb_fib_seq_ctrl;

    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] n_in;
    logic [BW-1:0] alu_out;
    logic [3:0]    alu_psw;
    logic [BW-1:0] opa, opb;
    logic [3:0]    sel;
    logic          busy, done, ovf;
    logic [BW-1:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Bench-side ALU: unsigned add with flags {z,n,c,v}.
    logic [BW:0] sum_w;
    assign sum_w   = {1'b0, opa} + {1'b0, opb};
    assign alu_out = sum_w[BW-1:0];
    assign alu_psw = {(sum_w[BW-1:0] == '0), sum_w[BW-1], sum_w[BW],
                      (opa[BW-1] == opb[BW-1]) && (sum_w[BW-1] != opa[BW-1])};

    fib_seq_ctrl #(.bw(BW), .SEL_ADD(4'b0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n       (n_in),
        .alu_out (alu_out),
        .alu_psw (alu_psw),
        .opa     (opa),
        .opb     (opb),
        .sel     (sel),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf)
    );

    // Accept a start for index nv, then wait for done and check latency,
    // result, overflow and that done lasts exactly one cycle.
    task automatic run_fib(input string name, input logic [BW-1:0] nv,
                           input logic [BW-1:0] exp_res, input logic exp_ovf,
                           input int exp_lat);
        int lat;
        @(negedge clk);
        start = 1'b1;
        n_in  = nv;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: done=%b after %0d cycles, required 1", name, done, lat);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %0d required %0d", name, result, exp_res);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s ovf: got %b required %b", name, ovf, exp_ovf);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b required 0", name, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width: got %b required 0", name, done);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        n_in  = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL reset_idle_ctrl: busy=%b done=%b required 0 0", busy, done);
            end
        end
        checks++;
        if ({busy, done, ovf} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy,done,ovf=%b required 000", {busy, done, ovf});
        end
        checks++;
        if (result !== 8'd0) begin
            errors++;
            $display("FAIL reset_result: got %0d required 0", result);
        end
        checks++;
        if (opa !== 8'd0 || opb !== 8'd0) begin
            errors++;
            $display("FAIL reset_operands: opa=%0d opb=%0d required 0 0", opa, opb);
        end
        checks++;
        if (sel !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sel: got %b required 0000", sel);
        end
    endtask

    task automatic test_small;
        run_fib("n0", 8'd0, 8'd0, 1'b0, 1);
        run_fib("n1", 8'd1, 8'd1, 1'b0, 2);
        run_fib("n2", 8'd2, 8'd1, 1'b0, 3);
        run_fib("n7", 8'd7, 8'd13, 1'b0, 8);
    endtask

    task automatic test_max_fit;
        run_fib("n13", 8'd13, 8'd233, 1'b0, 14);
    endtask

    task automatic test_overflow;
        run_fib("n14", 8'd14, 8'd121, 1'b1, 14);
        run_fib("n20", 8'd20, 8'd121, 1'b1, 14);
        // A clean run afterwards must clear the overflow flag.
        run_fib("n4_after_ovf", 8'd4, 8'd3, 1'b0, 5);
    endtask

    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        start = 1'b1;
        n_in  = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (3) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        start = 1'b1;
        n_in  = 8'd3;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL ignore_latency: got %0d required 11", lat);
        end
        checks++;
        if (result !== 8'd55) begin
            errors++;
            $display("FAIL ignore_result: got %0d required 55", result);
        end
        @(posedge clk); #1;
        run_fib("rearm_n3", 8'd3, 8'd2, 1'b0, 4);
    endtask

    task automatic test_back_to_back;
        int first, second, cyc;
        first  = -1;
        second = -1;
        @(negedge clk);
        start = 1'b1;
        n_in  = 8'd1;
        @(posedge clk); #1;
        cyc = 1;
        while (second < 0 && cyc < 50) begin
            if (done) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (first !== 2) begin
            errors++;
            $display("FAIL b2b_first_done: at cycle %0d required 2", first);
        end
        checks++;
        if (second - first !== 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required 3", second - first);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run;
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        start = 1'b1;
        n_in  = 8'd12;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, ovf} !== 3'b000 || result !== 8'd0 || opa !== 8'd0 || opb !== 8'd0) begin
            errors++;
            $display("FAIL midrun_reset_clear: busy=%b done=%b ovf=%b result=%0d opa=%0d opb=%0d required all 0",
                     busy, done, ovf, result, opa, opb);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: saw %0d done pulses required 0", seen_done);
        end
        run_fib("after_reset_n5", 8'd5, 8'd5, 1'b0, 6);
    endtask

    initial begin
        test_reset();
        test_small();
        test_max_fit();
        test_overflow();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
